// File: rtl/subckt_stim_driver_pkg.sv
// subckt_stim_driver_pkg: shared FSM states, mode encodings, LFSR taps and popcount helper
package subckt_stim_driver_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {MODE_CNT = 1'b0, MODE_LFSR = 1'b1} mode_t;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;
  localparam int POP_W = 32;
  function automatic logic [5:0] popcount(input logic [POP_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < POP_W; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/subckt_lfsr.sv
// subckt_lfsr: Fibonacci LFSR with load and enable; ports clk, rst_n, enable, load, seed -> state, nxt
module subckt_lfsr #(
  parameter int N = 4,
  parameter logic [N-1:0] TAPS = 4'b1100,
  parameter logic [N-1:0] RST_VAL = 4'b0001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] state,
  output logic [N-1:0] nxt
);
  assign nxt = {state[N-2:0], ^(state & TAPS)};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RST_VAL;
    else if (load) state <= seed;
    else if (enable) state <= nxt;
endmodule

// File: rtl/subckt_stim_driver.sv
// subckt_stim_driver: applies count/LFSR vectors to a sub-circuit and accumulates activity counters
// ports: clk, rst_n, start, mode, num_vec in; stim, busy, done, vec/ones/tgl/in_tgl counters out; dut_out in
module subckt_stim_driver
  import subckt_stim_driver_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int CNT_W = 16,
  parameter logic [N_IN-1:0] LFSR_SEED = 4'b0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] tgl_cnt,
  output logic [CNT_W-1:0] in_tgl_cnt
);
  localparam logic [N_IN-1:0] SEED_FIX = (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
  state_t state, state_nxt;
  mode_t mode_q;
  logic [CNT_W-1:0] num_q;
  logic [N_IN-1:0] cnt_q, lfsr_state, lfsr_nxt, stim_nxt;
  logic prev_out, accept, last;
  logic [CNT_W:0] in_sum;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign accept = state == IDLE && start;
  assign last = vec_cnt + CNT_W'(1) == num_q;
  // stim is only driven while running, so IDLE/DONE and reset all present 0
  assign stim = busy ? (mode_q == MODE_LFSR ? lfsr_state : cnt_q) : '0;
  assign stim_nxt = mode_q == MODE_LFSR ? lfsr_nxt : cnt_q + N_IN'(1);
  assign in_sum = {1'b0, in_tgl_cnt} + (CNT_W+1)'(popcount(POP_W'(stim ^ stim_nxt)));
  subckt_lfsr #(.N(N_IN), .TAPS(LFSR_TAPS), .RST_VAL(SEED_FIX)) u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .enable(busy && mode_q == MODE_LFSR),
    .load(accept),
    .seed(SEED_FIX),
    .state(lfsr_state),
    .nxt(lfsr_nxt)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? (num_vec == '0 ? DONE : RUN) : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q     <= MODE_CNT;
      num_q      <= '0;
      cnt_q      <= '0;
      prev_out   <= 1'b0;
      vec_cnt    <= '0;
      ones_cnt   <= '0;
      tgl_cnt    <= '0;
      in_tgl_cnt <= '0;
    end else if (accept) begin
      mode_q     <= mode_t'(mode);
      num_q      <= num_vec;
      cnt_q      <= '0;
      prev_out   <= 1'b0;
      vec_cnt    <= '0;
      ones_cnt   <= '0;
      tgl_cnt    <= '0;
      in_tgl_cnt <= '0;
    end else if (busy) begin
      vec_cnt  <= vec_cnt + CNT_W'(1);
      ones_cnt <= ones_cnt + CNT_W'(dut_out);
      tgl_cnt  <= tgl_cnt + CNT_W'(vec_cnt != '0 && dut_out != prev_out);
      prev_out <= dut_out;
      cnt_q    <= stim_nxt;
      // the final sample has no successor vector, so it contributes no input toggles
      if (!last) in_tgl_cnt <= in_sum[CNT_W] ? '1 : in_sum[CNT_W-1:0];
    end
endmodule
